// File: rtl/usb_bit_encoder.sv
// -----------------------------------------------------------------------------
// usb_bit_encoder
//
// Line-encoding stage that sits directly after the USB packet sender. It takes
// the raw serial packet stream (one bit per clock, LSB first, starting with
// SYNC), inserts a 0 after every run of STUFF_LIMIT ones, NRZI-encodes the
// result onto DP/DM, and closes every packet with an EOP: EOP_SE0_BITS cycles
// of SE0, then EOP_J_BITS cycles of J. After that the bus is idle at J.
//
// Timing model: the state names the decision being made in the current cycle.
// The bus registers are loaded on the clock edge that ends that cycle, so an
// accepted bit appears on DP/DM one cycle after the edge that accepted it.
// The STUFF cycle therefore shows the last 1 of the run with bit_ready low,
// and the stuffed 0 appears on the bus when that cycle ends.
//
// Ports:
//   clock      in   system clock, one USB bit time per cycle
//   reset      in   asynchronous, active-high reset
//   bit_in     in   raw packet bit
//   bit_valid  in   bit_in is valid this cycle
//   bit_last   in   bit_in is the final bit of the packet
//   bit_ready  out  encoder accepts bit_in this cycle (decoded from state)
//   DP_out     out  D+ line (registered)
//   DM_out     out  D- line (registered)
//   busy       out  packet in progress (state is not IDLE)
//   tx_done    out  one-cycle pulse together with the final EOP J bit
//   underrun   out  one-cycle pulse when bit_valid drops mid-packet
// -----------------------------------------------------------------------------
module usb_bit_encoder #(
   parameter int unsigned STUFF_LIMIT  = 6,
   parameter int unsigned EOP_SE0_BITS = 2,
   parameter int unsigned EOP_J_BITS   = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic bit_in,
   input  logic bit_valid,
   input  logic bit_last,
   output logic bit_ready,
   output logic DP_out,
   output logic DM_out,
   output logic busy,
   output logic tx_done,
   output logic underrun
);

   localparam int unsigned ONES_W   = $clog2(STUFF_LIMIT + 1);
   localparam int unsigned EOP_MAX  = (EOP_SE0_BITS > EOP_J_BITS) ? EOP_SE0_BITS : EOP_J_BITS;
   localparam int unsigned EOP_W    = (EOP_MAX > 1) ? $clog2(EOP_MAX) : 1;

   localparam logic [ONES_W-1:0] ONES_LIMIT = ONES_W'(STUFF_LIMIT);
   localparam logic [EOP_W-1:0]  SE0_LAST   = EOP_W'(EOP_SE0_BITS - 1);
   localparam logic [EOP_W-1:0]  J_LAST     = EOP_W'(EOP_J_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_STUFF,
      ST_EOP_SE0,
      ST_EOP_J
   } state_t;

   state_t              r_state,     w_state_nxt;
   logic [ONES_W-1:0]   r_ones_cnt,  w_ones_cnt_nxt;
   logic [EOP_W-1:0]    r_eop_cnt,   w_eop_cnt_nxt;
   logic                r_level,     w_level_nxt;
   logic                r_last_pend, w_last_pend_nxt;
   logic                r_dp,        w_dp_nxt;
   logic                r_dm,        w_dm_nxt;
   logic                r_tx_done,   w_tx_done_nxt;
   logic                r_underrun,  w_underrun_nxt;

   logic                w_ready;
   logic                w_accept;
   logic                w_enc_level;
   logic [ONES_W-1:0]   w_ones_inc;
   logic                w_stuff_hit;

   assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DATA);
   assign w_accept = bit_valid && w_ready;

   // NRZI: a 0 toggles the line level, a 1 holds it.
   assign w_enc_level = bit_in ? r_level : ~r_level;
   assign w_ones_inc  = bit_in ? (r_ones_cnt + ONES_W'(1)) : '0;
   assign w_stuff_hit = bit_in && (w_ones_inc == ONES_LIMIT);

   // Next-state and next-output logic.
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt     = r_state;
      w_ones_cnt_nxt  = r_ones_cnt;
      w_eop_cnt_nxt   = r_eop_cnt;
      w_level_nxt     = r_level;
      w_last_pend_nxt = r_last_pend;
      w_dp_nxt        = r_dp;
      w_dm_nxt        = r_dm;
      w_tx_done_nxt   = 1'b0;
      w_underrun_nxt  = 1'b0;

      unique case (r_state)
         ST_IDLE, ST_DATA: begin
            // IDLE always holds ones_cnt=0 and level=1, so the same accept
            // path starts a packet correctly.
            if (w_accept) begin
               w_level_nxt    = w_enc_level;
               w_dp_nxt       = w_enc_level;
               w_dm_nxt       = ~w_enc_level;
               w_ones_cnt_nxt = w_ones_inc;
               if (w_stuff_hit) begin
                  w_state_nxt     = ST_STUFF;
                  w_last_pend_nxt = bit_last;
               end else if (bit_last) begin
                  w_state_nxt   = ST_EOP_SE0;
                  w_eop_cnt_nxt = '0;
               end else begin
                  w_state_nxt = ST_DATA;
               end
            end else if (r_state == ST_DATA) begin
               // Sender starved us mid-packet: the line holds its level for
               // this bit time and the packet is closed with a normal EOP.
               w_underrun_nxt = 1'b1;
               w_state_nxt    = ST_EOP_SE0;
               w_eop_cnt_nxt  = '0;
            end
         end

         ST_STUFF: begin
            // Stuffed 0 is NRZI-encoded like data: the level toggles.
            w_level_nxt    = ~r_level;
            w_dp_nxt       = ~r_level;
            w_dm_nxt       = r_level;
            w_ones_cnt_nxt = '0;
            if (r_last_pend) begin
               w_state_nxt     = ST_EOP_SE0;
               w_eop_cnt_nxt   = '0;
               w_last_pend_nxt = 1'b0;
            end else begin
               w_state_nxt = ST_DATA;
            end
         end

         ST_EOP_SE0: begin
            w_dp_nxt = 1'b0;
            w_dm_nxt = 1'b0;
            if (r_eop_cnt == SE0_LAST) begin
               w_state_nxt   = ST_EOP_J;
               w_eop_cnt_nxt = '0;
            end else begin
               w_eop_cnt_nxt = r_eop_cnt + EOP_W'(1);
            end
         end

         ST_EOP_J: begin
            w_dp_nxt = 1'b1;
            w_dm_nxt = 1'b0;
            if (r_eop_cnt == J_LAST) begin
               // Final J bit: re-arm everything for the next packet.
               w_state_nxt     = ST_IDLE;
               w_tx_done_nxt   = 1'b1;
               w_eop_cnt_nxt   = '0;
               w_ones_cnt_nxt  = '0;
               w_level_nxt     = 1'b1;
               w_last_pend_nxt = 1'b0;
            end else begin
               w_eop_cnt_nxt = r_eop_cnt + EOP_W'(1);
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_ones_cnt  <= '0;
         r_eop_cnt   <= '0;
         r_level     <= 1'b1;
         r_last_pend <= 1'b0;
         r_dp        <= 1'b1;
         r_dm        <= 1'b0;
         r_tx_done   <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ones_cnt  <= w_ones_cnt_nxt;
         r_eop_cnt   <= w_eop_cnt_nxt;
         r_level     <= w_level_nxt;
         r_last_pend <= w_last_pend_nxt;
         r_dp        <= w_dp_nxt;
         r_dm        <= w_dm_nxt;
         r_tx_done   <= w_tx_done_nxt;
         r_underrun  <= w_underrun_nxt;
      end
   end

   assign bit_ready = w_ready;
   assign DP_out    = r_dp;
   assign DM_out    = r_dm;
   assign busy      = (r_state != ST_IDLE);
   assign tx_done   = r_tx_done;
   assign underrun  = r_underrun;

endmodule

// File: tb/tb_usb_bit_encoder.sv
// -----------------------------------------------------------------------------
// tb_usb_bit_encoder
//
// Directed bench for usb_bit_encoder. Each cycle drives one set of sender
// inputs, records bit_ready before the edge, and after the edge compares the
// packed observation {bit_ready, DP, DM, tx_done, underrun, busy} against a
// hand-computed expectation.
// -----------------------------------------------------------------------------
module tb_usb_bit_encoder;

   localparam logic [1:0] J = 2'b10;
   localparam logic [1:0] K = 2'b01;
   localparam logic [1:0] S = 2'b00;

   logic clock;
   logic reset;
   logic bit_in;
   logic bit_valid;
   logic bit_last;
   logic bit_ready;
   logic DP_out;
   logic DM_out;
   logic busy;
   logic tx_done;
   logic underrun;

   int n_checks;
   int n_errors;

   usb_bit_encoder #(
      .STUFF_LIMIT  (6),
      .EOP_SE0_BITS (2),
      .EOP_J_BITS   (1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .bit_last  (bit_last),
      .bit_ready (bit_ready),
      .DP_out    (DP_out),
      .DM_out    (DM_out),
      .busy      (busy),
      .tx_done   (tx_done),
      .underrun  (underrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [5:0] ex(input logic rdy, input logic [1:0] bus,
                                     input logic td, input logic ur, input logic bsy);
      return {rdy, bus, td, ur, bsy};
   endfunction

   task automatic check(input string tag, input logic [5:0] act, input logic [5:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got {rdy,dp,dm,td,ur,busy}=%b expected %b", tag, act, exp);
      end
   endtask

   // One bit time: drive inputs, note bit_ready, clock, then compare.
   task automatic cyc(input string tag, input logic v, input logic b, input logic l,
                      input logic [5:0] exp);
      logic rdy;
      bit_valid = v;
      bit_in    = b;
      bit_last  = l;
      rdy       = bit_ready;
      @(posedge clock);
      #1;
      check(tag, {rdy, DP_out, DM_out, tx_done, underrun, busy}, exp);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b1;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      bit_last  = 1'b0;

      // Reset state
      #12;
      check("reset_state", {bit_ready, DP_out, DM_out, tx_done, underrun, busy}, ex(1, J, 0, 0, 0));
      reset = 1'b0;
      @(posedge clock);
      #1;

      // SYNC only: 0000000 then 1 (last) -> K J K J K J K K, SE0 SE0, J+tx_done
      for (int i = 0; i < 7; i++)
         cyc($sformatf("sync_b%0d", i), 1, 0, 0, ex(1, (i % 2 == 0) ? K : J, 0, 0, 1));
      cyc("sync_b7",   1, 1, 1, ex(1, K, 0, 0, 1));
      cyc("sync_se0a", 0, 0, 0, ex(0, S, 0, 0, 1));
      cyc("sync_se0b", 0, 0, 0, ex(0, S, 0, 0, 1));
      cyc("sync_j",    0, 0, 0, ex(0, J, 1, 0, 0));
      cyc("sync_idle", 0, 0, 0, ex(1, J, 0, 0, 0));

      // 0,0, eight 1s, 0(last): stuff after sixth 1, remaining 1s held
      cyc("st8_b0", 1, 0, 0, ex(1, K, 0, 0, 1));
      cyc("st8_b1", 1, 0, 0, ex(1, J, 0, 0, 1));
      for (int i = 0; i < 6; i++)
         cyc($sformatf("st8_one%0d", i + 1), 1, 1, 0, ex(1, J, 0, 0, 1));
      cyc("st8_stuff", 1, 1, 0, ex(0, K, 0, 0, 1));
      cyc("st8_one7",  1, 1, 0, ex(1, K, 0, 0, 1));
      cyc("st8_one8",  1, 1, 0, ex(1, K, 0, 0, 1));
      cyc("st8_last0", 1, 0, 1, ex(1, J, 0, 0, 1));
      cyc("st8_se0a",  0, 0, 0, ex(0, S, 0, 0, 1));
      cyc("st8_se0b",  0, 0, 0, ex(0, S, 0, 0, 1));
      cyc("st8_j",     0, 0, 0, ex(0, J, 1, 0, 0));
      cyc("st8_idle",  0, 0, 0, ex(1, J, 0, 0, 0));

      // 0 then six 1s with last on the sixth: stuffed 0 precedes EOP
      cyc("st6_b0", 1, 0, 0, ex(1, K, 0, 0, 1));
      for (int i = 0; i < 5; i++)
         cyc($sformatf("st6_one%0d", i + 1), 1, 1, 0, ex(1, K, 0, 0, 1));
      cyc("st6_one6",  1, 1, 1, ex(1, K, 0, 0, 1));
      cyc("st6_stuff", 0, 0, 0, ex(0, J, 0, 0, 1));
      cyc("st6_se0a",  0, 0, 0, ex(0, S, 0, 0, 1));
      cyc("st6_se0b",  0, 0, 0, ex(0, S, 0, 0, 1));
      cyc("st6_j",     0, 0, 0, ex(0, J, 1, 0, 0));
      cyc("st6_idle",  0, 0, 0, ex(1, J, 0, 0, 0));

      // Underrun: 0,0,1 then bit_valid drops; later bits are refused
      cyc("ur_b0",   1, 0, 0, ex(1, K, 0, 0, 1));
      cyc("ur_b1",   1, 0, 0, ex(1, J, 0, 0, 1));
      cyc("ur_b2",   1, 1, 0, ex(1, J, 0, 0, 1));
      cyc("ur_drop", 0, 0, 0, ex(1, J, 0, 1, 1));
      cyc("ur_se0a", 1, 1, 0, ex(0, S, 0, 0, 1));
      cyc("ur_se0b", 1, 1, 0, ex(0, S, 0, 0, 1));
      cyc("ur_j",    1, 1, 0, ex(0, J, 1, 0, 0));
      cyc("ur_idle", 0, 0, 0, ex(1, J, 0, 0, 0));

      // One-bit packet, then reset pulse during SE0: immediate J, no tx_done
      cyc("one_bit",  1, 1, 1, ex(1, J, 0, 0, 1));
      cyc("one_se0a", 0, 0, 0, ex(0, S, 0, 0, 1));
      #2;
      reset = 1'b1;
      #1;
      check("rst_mid_se0", {bit_ready, DP_out, DM_out, tx_done, underrun, busy}, ex(1, J, 0, 0, 0));
      #2;
      reset = 1'b0;
      for (int i = 0; i < 3; i++)
         cyc($sformatf("rst_after%0d", i), 0, 0, 0, ex(1, J, 0, 0, 0));

      // Back-to-back SYNC packets with bit_valid held high
      for (int i = 0; i < 7; i++)
         cyc($sformatf("b2b_a%0d", i), 1, 0, 0, ex(1, (i % 2 == 0) ? K : J, 0, 0, 1));
      cyc("b2b_a7",   1, 1, 1, ex(1, K, 0, 0, 1));
      cyc("b2b_se0a", 1, 0, 0, ex(0, S, 0, 0, 1));
      cyc("b2b_se0b", 1, 0, 0, ex(0, S, 0, 0, 1));
      cyc("b2b_j",    1, 0, 0, ex(0, J, 1, 0, 0));
      for (int i = 0; i < 7; i++)
         cyc($sformatf("b2b_b%0d", i), 1, 0, 0, ex(1, (i % 2 == 0) ? K : J, 0, 0, 1));
      cyc("b2b_b7",    1, 1, 1, ex(1, K, 0, 0, 1));
      cyc("b2b_se0c",  0, 0, 0, ex(0, S, 0, 0, 1));
      cyc("b2b_se0d",  0, 0, 0, ex(0, S, 0, 0, 1));
      cyc("b2b_j2",    0, 0, 0, ex(0, J, 1, 0, 0));
      cyc("b2b_idle",  0, 0, 0, ex(1, J, 0, 0, 0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
